// File: rtl/read_empty_gen_pkg.sv
// Shared pointer constants and Gray/binary conversions for the async FIFO status stages.
// Conversions work on a wide vector; callers zero-extend narrower pointers and truncate the result.
package read_empty_gen_pkg;

  localparam int A_LENGTH_DEF = 3;
  localparam int PTR_W_DEF    = A_LENGTH_DEF + 1;
  localparam int CONV_W       = 32;

  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extension is harmless here: leading zero bits do not change the running XOR.
  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
    logic [CONV_W-1:0] b;
    b[CONV_W-1] = g[CONV_W-1];
    for (int i = CONV_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/read_empty_gen_if.sv
// Read-side pointer/status bundle between the read counter, this stage and the write domain.
interface read_empty_gen_if #(
  parameter int a_length = 3
);
  localparam int PTR_W = a_length + 1;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_gray;
  logic             f_empty;
  logic             f_almost_empty;
  logic [PTR_W-1:0] rd_level;
  logic [PTR_W-1:0] rd_ptr_gray;

  modport master (
    output rd_ptr,
    output wr_ptr_gray,
    input  f_empty,
    input  f_almost_empty,
    input  rd_level,
    input  rd_ptr_gray
  );

  modport slave (
    input  rd_ptr,
    input  wr_ptr_gray,
    output f_empty,
    output f_almost_empty,
    output rd_level,
    output rd_ptr_gray
  );
endinterface

// File: rtl/read_empty_gen_sync_2ff.sv
// Plain two-flop synchronizer; also used on the write side for the Gray read pointer.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             rd_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q1;
  logic [WIDTH-1:0] r_q2;

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      r_q1 <= '0;
      r_q2 <= '0;
    end else begin
      r_q1 <= d;
      r_q2 <= r_q1;
    end
  end

  assign q = r_q2;

endmodule

// File: rtl/read_empty_gen.sv
// Read-domain empty/almost-empty/level generator for the async FIFO, plus the exported Gray read pointer.
// Status is computed against the read pointer the counter will hold after this edge, so flags never lag a read.
module read_empty_gen
  import read_empty_gen_pkg::*;
#(
  parameter int a_length = A_LENGTH_DEF,
  parameter int AE_LEVEL = 1
) (
  input logic             rd_clk,
  input logic             reset,
  read_empty_gen_if.slave bus
);

  localparam int               PTR_W  = a_length + 1;
  localparam logic [PTR_W-1:0] AE_THR = PTR_W'(AE_LEVEL);

  logic [PTR_W-1:0] w_wr_sync;
  logic [PTR_W-1:0] w_wr_bin;
  logic [PTR_W-1:0] w_rd_next;
  logic [PTR_W-1:0] w_level;

  logic             r_empty;
  logic             r_almost_empty;
  logic [PTR_W-1:0] r_level;
  logic [PTR_W-1:0] r_rd_gray;

  sync_2ff #(
    .WIDTH (PTR_W)
  ) u_sync (
    .rd_clk (rd_clk),
    .reset  (reset),
    .d      (bus.wr_ptr_gray),
    .q      (w_wr_sync)
  );

  assign w_wr_bin  = PTR_W'(gray2bin(CONV_W'(w_wr_sync)));
  // Mirrors the read counter's own increment on this edge (enable = ~f_empty).
  assign w_rd_next = bus.rd_ptr + {{(PTR_W-1){1'b0}}, ~r_empty};
  assign w_level   = w_wr_bin - w_rd_next;

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_level        <= '0;
      r_rd_gray      <= '0;
    end else begin
      r_empty        <= (w_rd_next == w_wr_bin);
      r_almost_empty <= (w_level <= AE_THR);
      r_level        <= w_level;
      r_rd_gray      <= PTR_W'(bin2gray(CONV_W'(w_rd_next)));
    end
  end

  assign bus.f_empty        = r_empty;
  assign bus.f_almost_empty = r_almost_empty;
  assign bus.rd_level       = r_level;
  assign bus.rd_ptr_gray    = r_rd_gray;

endmodule

// File: tb/tb_read_empty_gen.sv
// Scoreboard bench for read_empty_gen with a modelled read counter (rd_ptr += ~f_empty).
module tb_read_empty_gen;

  localparam int AL = 3;
  localparam int PW = AL + 1;
  localparam int AE = 1;

  typedef logic [2*PW+1:0] obs_t;  // {f_empty, f_almost_empty, rd_level, rd_ptr_gray}

  logic clk = 1'b0;
  logic reset;

  read_empty_gen_if #(.a_length(AL)) bus ();

  read_empty_gen #(
    .a_length (AL),
    .AE_LEVEL (AE)
  ) dut (
    .rd_clk (clk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #500 clk = ~clk;

  obs_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   reads = 0;

  logic [PW-1:0] m_q1, m_q2, m_level, m_gray;
  logic          m_empty, m_ae;

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic obs_t observe();
    return {bus.f_empty, bus.f_almost_empty, bus.rd_level, bus.rd_ptr_gray};
  endfunction

  // One rd_clk edge: update reference model, push expectation, advance, then step the read counter.
  task automatic tick(input logic rst);
    logic          e;
    logic [PW-1:0] wb, rn;
    reset = rst;
    if (rst) begin
      m_q1 = '0; m_q2 = '0; m_empty = 1'b1; m_ae = 1'b1; m_level = '0; m_gray = '0;
    end else begin
      wb      = g2b(m_q2);
      rn      = bus.rd_ptr + (m_empty ? 4'd0 : 4'd1);
      m_empty = (rn == wb);
      m_level = wb - rn;
      m_ae    = (m_level <= PW'(AE));
      m_gray  = rn ^ (rn >> 1);
      m_q2    = m_q1;
      m_q1    = bus.wr_ptr_gray;
    end
    sb.push_back({m_empty, m_ae, m_level, m_gray});
    e = bus.f_empty;
    @(posedge clk);
    #1;
    if (rst) begin
      bus.rd_ptr = '0;
    end else if (e === 1'b0) begin
      bus.rd_ptr = bus.rd_ptr + 1'b1;
      reads++;
    end
  endtask

  task automatic test_reset();
    obs_t x, got, rst_obs;
    rst_obs = {1'b1, 1'b1, 4'b0000, 4'b0000};
    bus.rd_ptr      = '0;
    bus.wr_ptr_gray = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      tick(1'b1);
      x = sb.pop_front(); got = observe();
      n_cmp++;
      if (got !== x) begin n_err++; $display("FAIL reset_model edge%0d: got %b expected %b", k, got, x); end
      n_cmp++;
      if (got !== rst_obs) begin n_err++; $display("FAIL reset_value edge%0d: got %b expected %b", k, got, rst_obs); end
    end
    bus.wr_ptr_gray = '0;
    tick(1'b1);
    void'(sb.pop_front());
    for (int k = 0; k < 3; k++) begin
      tick(1'b0);
      x = sb.pop_front(); got = observe();
      n_cmp++;
      if (got !== x) begin n_err++; $display("FAIL idle_model cyc%0d: got %b expected %b", k, got, x); end
    end
  endtask

  task automatic test_single_write();
    obs_t          x, got;
    logic          exp_e[4];
    logic [PW-1:0] exp_l[4];
    exp_e = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp_l = '{4'd0, 4'd0, 4'd1, 4'd0};
    reads = 0;
    bus.wr_ptr_gray = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      tick(1'b0);
      x = sb.pop_front(); got = observe();
      n_cmp++;
      if (got !== x) begin n_err++; $display("FAIL single_model N+%0d: got %b expected %b", k, got, x); end
      n_cmp++;
      if (bus.f_empty !== exp_e[k]) begin n_err++; $display("FAIL single_empty N+%0d: got %b expected %b", k, bus.f_empty, exp_e[k]); end
      n_cmp++;
      if (bus.rd_level !== exp_l[k]) begin n_err++; $display("FAIL single_level N+%0d: got %0d expected %0d", k, bus.rd_level, exp_l[k]); end
    end
    n_cmp++;
    if (bus.rd_ptr !== 4'd1 || reads != 1) begin
      n_err++; $display("FAIL single_reads: rd_ptr %0d reads %0d expected 1/1", bus.rd_ptr, reads);
    end
  endtask

  task automatic test_burst();
    obs_t x, got;
    int   peak = 0;
    bit   done = 0;
    bus.wr_ptr_gray = '0;
    tick(1'b1);
    void'(sb.pop_front());
    repeat (2) begin tick(1'b0); void'(sb.pop_front()); end
    reads = 0;
    for (int w = 1; w <= 8; w++) begin
      bus.wr_ptr_gray = b2g(PW'(w));
      tick(1'b0);
      x = sb.pop_front(); got = observe();
      n_cmp++;
      if (got !== x) begin n_err++; $display("FAIL burst_model w%0d: got %b expected %b", w, got, x); end
      if (int'(bus.rd_level) > peak) peak = int'(bus.rd_level);
      if (bus.rd_level >= 4'd2) begin
        n_cmp++;
        if (bus.f_almost_empty !== 1'b0) begin n_err++; $display("FAIL burst_ae level%0d: got %b expected 0", bus.rd_level, bus.f_almost_empty); end
      end
    end
    for (int k = 0; k < 20 && !done; k++) begin
      tick(1'b0);
      x = sb.pop_front(); got = observe();
      n_cmp++;
      if (got !== x) begin n_err++; $display("FAIL drain_model cyc%0d: got %b expected %b", k, got, x); end
      if (int'(bus.rd_level) > peak) peak = int'(bus.rd_level);
      if (bus.f_empty === 1'b1 && bus.rd_ptr == 4'd8) done = 1;
    end
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL burst_drain_timeout: rd_ptr %0d expected 8", bus.rd_ptr); end
    n_cmp++;
    if (bus.rd_ptr_gray !== 4'b1100 || bus.f_empty !== 1'b1 || reads != 8) begin
      n_err++; $display("FAIL burst_end: gray %b empty %b reads %0d expected 1100/1/8", bus.rd_ptr_gray, bus.f_empty, reads);
    end
    n_cmp++;
    if (peak > 8) begin n_err++; $display("FAIL burst_peak: got %0d expected <=8", peak); end
  endtask

  task automatic test_wrap();
    obs_t x, got;
    int   peak = 0;
    bit   done = 0;
    for (int w = 9; w <= 14; w++) begin
      bus.wr_ptr_gray = b2g(PW'(w));
      tick(1'b0);
      x = sb.pop_front(); got = observe();
      n_cmp++;
      if (got !== x) begin n_err++; $display("FAIL prewrap_model w%0d: got %b expected %b", w, got, x); end
    end
    for (int k = 0; k < 20 && !done; k++) begin
      tick(1'b0);
      x = sb.pop_front(); got = observe();
      n_cmp++;
      if (got !== x) begin n_err++; $display("FAIL prewrap_drain cyc%0d: got %b expected %b", k, got, x); end
      if (bus.f_empty === 1'b1 && bus.rd_ptr == 4'd14) done = 1;
    end
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL prewrap_timeout: rd_ptr %0d expected 14", bus.rd_ptr); end
    reads = 0;
    done  = 0;
    bus.wr_ptr_gray = 4'b1000;
    tick(1'b0);
    x = sb.pop_front(); got = observe();
    n_cmp++;
    if (got !== x) begin n_err++; $display("FAIL wrap_model w15: got %b expected %b", got, x); end
    bus.wr_ptr_gray = 4'b0000;
    for (int k = 0; k < 20 && !done; k++) begin
      tick(1'b0);
      x = sb.pop_front(); got = observe();
      n_cmp++;
      if (got !== x) begin n_err++; $display("FAIL wrap_model cyc%0d: got %b expected %b", k, got, x); end
      if (int'(bus.rd_level) > peak) peak = int'(bus.rd_level);
      if (bus.f_empty === 1'b1 && bus.rd_ptr == 4'd0 && reads > 0) done = 1;
    end
    n_cmp++;
    if (!done || reads != 2 || bus.rd_ptr_gray !== 4'b0000) begin
      n_err++; $display("FAIL wrap_end: reads %0d rd_ptr %0d gray %b expected 2/0/0000", reads, bus.rd_ptr, bus.rd_ptr_gray);
    end
    n_cmp++;
    if (peak > 2) begin n_err++; $display("FAIL wrap_peak: got %0d expected <=2", peak); end
  endtask

  task automatic test_reset_mid_drain();
    obs_t x, got;
    bit   hit = 0;
    bus.wr_ptr_gray = b2g(4'd5);
    for (int k = 0; k < 10 && !hit; k++) begin
      tick(1'b0);
      x = sb.pop_front(); got = observe();
      n_cmp++;
      if (got !== x) begin n_err++; $display("FAIL mid_fill_model cyc%0d: got %b expected %b", k, got, x); end
      if (bus.rd_level == 4'd5) hit = 1;
    end
    n_cmp++;
    if (!hit) begin n_err++; $display("FAIL mid_fill_timeout: level %0d expected 5", bus.rd_level); end
    bus.wr_ptr_gray = '0;
    tick(1'b1);
    x = sb.pop_front(); got = observe();
    n_cmp++;
    if (got !== {1'b1, 1'b1, 4'b0000, 4'b0000}) begin n_err++; $display("FAIL mid_reset: got %b expected 1100000000", got); end
    reads = 0;
    for (int k = 0; k < 2; k++) begin
      tick(1'b0);
      x = sb.pop_front(); got = observe();
      n_cmp++;
      if (got !== x || bus.f_empty !== 1'b1) begin n_err++; $display("FAIL post_reset edge%0d: got %b expected %b", k, got, x); end
    end
    n_cmp++;
    if (reads != 0 || bus.rd_ptr !== 4'd0) begin n_err++; $display("FAIL post_reset_reads: reads %0d rd_ptr %0d expected 0/0", reads, bus.rd_ptr); end
  endtask

  task automatic test_gray_glitch();
    obs_t          x, got;
    logic [PW-1:0] w = '0;
    bit            done = 0;
    for (int i = 0; i < 12; i++) begin
      // random extra cycle models the synchronizer resolving to the old value
      if ($urandom_range(0, 1) == 1) begin
        tick(1'b0);
        x = sb.pop_front(); got = observe();
        n_cmp++;
        if (got !== x) begin n_err++; $display("FAIL glitch_model_hold i%0d: got %b expected %b", i, got, x); end
      end
      #998;
      w = w + 1'b1;
      bus.wr_ptr_gray = b2g(w);
      tick(1'b0);
      x = sb.pop_front(); got = observe();
      n_cmp++;
      if (got !== x) begin n_err++; $display("FAIL glitch_model i%0d: got %b expected %b", i, got, x); end
      n_cmp++;
      if (bus.f_empty === 1'b0 && bus.rd_ptr == w) begin
        n_err++; $display("FAIL glitch_underflow i%0d: f_empty 0 with rd_ptr %0d == wr %0d", i, bus.rd_ptr, w);
      end
    end
    for (int k = 0; k < 20 && !done; k++) begin
      tick(1'b0);
      x = sb.pop_front(); got = observe();
      n_cmp++;
      if (got !== x) begin n_err++; $display("FAIL glitch_drain cyc%0d: got %b expected %b", k, got, x); end
      if (bus.f_empty === 1'b1 && bus.rd_ptr == w) done = 1;
    end
    n_cmp++;
    if (!done) begin n_err++; $display("FAIL glitch_drain_timeout: rd_ptr %0d expected %0d", bus.rd_ptr, w); end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    bus.rd_ptr      = '0;
    bus.wr_ptr_gray = '0;
    test_reset();
    test_single_write();
    test_burst();
    test_wrap();
    test_reset_mid_drain();
    test_gray_glitch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/read_empty_gen.md
Name: read_empty_gen

Overview:
- Read-domain status stage paired with the read pointer counter of the async FIFO.
- Consumes the binary read pointer produced by the read counter and the Gray-coded write pointer arriving from the write clock domain.
- Produces f_empty, which drives the read counter's enable (~f_empty), plus an almost-empty flag, a read-side fill level, and a registered Gray read pointer for export to the write domain.

Parameters:
a_length, 3, address width; pointers are a_length+1 bits (MSB = wrap bit); FIFO depth = 2**a_length
AE_LEVEL, 1, almost-empty threshold in words; f_almost_empty asserted when level <= AE_LEVEL

Ports:
rd_clk  input  1  read-domain clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset, sampled on rd_clk
rd_ptr  input  a_length+1  binary read pointer from read counter; increments by 1 on each rd_clk edge where f_empty=0
wr_ptr_gray  input  a_length+1  Gray write pointer from write domain; asynchronous to rd_clk; at most one bit changes per write
f_empty  output  1  registered empty flag; feeds read counter enable
f_almost_empty  output  1  registered; level <= AE_LEVEL
rd_level  output  a_length+1  registered words available, range 0..2**a_length
rd_ptr_gray  output  a_length+1  registered Gray code of rd_ptr, for the write-domain synchronizer

Behaviour:
- Reset is synchronous and active-high: on any rd_clk edge with reset=1, all registers clear regardless of other inputs.
  - sync stages = 0, rd_ptr_gray = 0, rd_level = 0, f_empty = 1, f_almost_empty = 1.
  - Reset has priority over every other update.
- Synchronizer: two-flop chain on wr_ptr_gray, sync_q1 <= wr_ptr_gray, sync_q2 <= sync_q1.
  - No logic between the flops.
  - No other logic samples wr_ptr_gray directly.
- wr_bin = Gray-to-binary of sync_q2 (combinational): bit i = XOR of sync_q2[a_length:i].
- Next read pointer prediction: rd_next = rd_ptr + (f_empty ? 0 : 1), modulo 2**(a_length+1).
  - This matches the read counter's own update on the same edge.
- Registered updates, each rd_clk edge without reset:
  - f_empty <= (rd_next == wr_bin).
  - rd_level <= wr_bin - rd_next, (a_length+1)-bit modulo subtraction. A correct result never exceeds 2**a_length.
  - f_almost_empty <= (wr_bin - rd_next) <= AE_LEVEL.
  - rd_ptr_gray <= rd_next ^ (rd_next >> 1), so the exported Gray pointer tracks the counter with no extra lag.
- Latency:
  - If wr_ptr_gray changes before edge N, sync_q2 holds the new value after edge N+1.
  - f_empty, rd_level and f_almost_empty reflect the new value after edge N+2.
- Empty detection compares full a_length+1 bits, wrap bit included. Equal pointers always mean empty; this block never reports full.
- Wrap-around: rd_ptr rolls over from 2**(a_length+1)-1 to 0. Prediction, level and Gray conversion are all modulo, with no special case.
- Simultaneous events: a new write seen through the synchronizer in the same cycle as a read is handled by the rd_next/wr_bin comparison. No read is lost or duplicated.
- Flags are pessimistic only: f_empty may stay high for up to 2 extra cycles after a write, but must never be low while the FIFO is empty.
- Reset mid-operation:
  - All outputs return to reset values on the next edge.
  - The system drives wr_ptr_gray to 0 via its own domain reset.
  - Within 2 edges, sync_q2 = 0 and f_empty stays 1.

Decomposition:
- Shared constants/header: a_length default and pointer width (a_length+1).
- Shared functions: bin2gray and gray2bin, common to the write-side counterpart.
- One sub-module: sync_2ff, parameter WIDTH, ports rd_clk, reset, d, q.
  - Reused by the write side for rd_ptr_gray.
- Gray conversion and level logic stay inline.

Test Plan (a_length=3, AE_LEVEL=1; the bench models the read counter, rd_ptr += ~f_empty):
1. Reset: assert reset 2 edges with wr_ptr_gray=0101 -> f_empty=1, f_almost_empty=1, rd_level=0, rd_ptr_gray=0000 on both edges.
2. Single write: rd_ptr=0; wr_ptr_gray 0000->0001 before edge N.
   - f_empty=1 after N and N+1; f_empty=0, rd_level=1 after N+2.
   - f_empty=1, rd_level=0 after N+3; rd_ptr ends at 1 (exactly one read).
3. Burst: wr_ptr_gray stepped 0->8 (gray 1100) one write per cycle.
   - rd_level peaks at or below 8; f_almost_empty=0 while level>=2.
   - FIFO drains to rd_ptr=8, rd_ptr_gray=1100, f_empty=1.
4. Wrap: preload rd_ptr=14; wr_ptr_gray steps gray(15)=1000 then gray(0)=0000.
   - Two reads occur; rd_ptr ends at 0, rd_ptr_gray=0000, f_empty=1; rd_level never exceeds 2.
5. Reset mid-drain: rd_level=5, assert reset one edge -> next edge f_empty=1, rd_level=0, rd_ptr_gray=0000; no read enable for 2 edges after deassertion with wr_ptr_gray=0.
6. Gray glitch tolerance: wr_ptr_gray changed 1 ps before an rd_clk edge (synchronizer metastability modelled as random old/new) -> f_empty never deasserts with rd_ptr equal to the true write pointer.
